// File: rtl/rv32i_types.sv
// Shared type definitions for the memory-side blocks.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_D = 2'd1,
        SERVE_I = 2'd2,
        RESP    = 2'd3
    } mem_arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port memory.
// Data wins ties; request fields are latched so the memory sees a stable request.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; arbitrate pending requests (data first)
// SERVE_D | data request issued downstream, waiting for mem_resp
// SERVE_I | fetch request issued downstream, waiting for mem_resp
// RESP    | one-cycle completion pulse on the served port
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_read,
    input  logic [31:0] imem_address,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [31:0] dmem_address,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        err_timeout
);
    import rv32i_types::*;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    mem_arb_state_t state_q, state_d;

    logic [31:0]      addr_q;
    logic [3:0]       wmask_q;
    logic [31:0]      wdata_q;
    logic             write_q;
    logic [31:0]      rdata_q;
    logic             served_d_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             err_q;
    logic             serving;
    logic             dmem_req;

    assign dmem_req     = dmem_read | dmem_write;
    assign serving      = (state_q == SERVE_D) || (state_q == SERVE_I);
    assign wait_cnt_inc = wait_cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dmem_req) begin
                    state_d = SERVE_D;
                end else if (imem_read) begin
                    state_d = SERVE_I;
                end
            end
            SERVE_D, SERVE_I: begin
                if (mem_resp) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wmask_q    <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            rdata_q    <= '0;
            served_d_q <= 1'b0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                wait_cnt_q <= '0;
                if (dmem_req) begin
                    addr_q  <= dmem_address;
                    wmask_q <= dmem_wmask;
                    wdata_q <= dmem_wdata;
                    write_q <= dmem_write;
                end else if (imem_read) begin
                    addr_q  <= imem_address;
                    wmask_q <= '0;
                    wdata_q <= '0;
                    write_q <= 1'b0;
                end
            end else if (serving) begin
                if (mem_resp) begin
                    // Write completions return zero data regardless of the memory bus.
                    rdata_q    <= write_q ? 32'h0 : mem_rdata;
                    served_d_q <= (state_q == SERVE_D);
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_q <= wait_cnt_inc;
                    if (wait_cnt_inc == CNT_MAX) begin
                        err_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign mem_read    = (state_q == SERVE_I) || ((state_q == SERVE_D) && !write_q);
    assign mem_write   = (state_q == SERVE_D) && write_q;
    assign mem_address = serving ? addr_q  : '0;
    assign mem_wmask   = serving ? wmask_q : '0;
    assign mem_wdata   = serving ? wdata_q : '0;

    assign imem_resp   = (state_q == RESP) && !served_d_q;
    assign dmem_resp   = (state_q == RESP) && served_d_q;
    assign imem_rdata  = imem_resp ? rdata_q : '0;
    assign dmem_rdata  = dmem_resp ? rdata_q : '0;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus hand-written
// sequences for arbitration, live-input changes, timeout and mid-transaction reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_address (dmem_address),
        .dmem_wmask   (dmem_wmask),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wmask    (mem_wmask),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          lat;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drop_reqs();
        imem_read    = 1'b0;
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        imem_address = '0;
        dmem_address = '0;
        dmem_wmask   = '0;
        dmem_wdata   = '0;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, " mem_read"},   {31'b0, mem_read},  32'h0);
        chk({nm, " mem_write"},  {31'b0, mem_write}, 32'h0);
        chk({nm, " imem_resp"},  {31'b0, imem_resp}, 32'h0);
        chk({nm, " dmem_resp"},  {31'b0, dmem_resp}, 32'h0);
        chk({nm, " imem_rdata"}, imem_rdata, 32'h0);
        chk({nm, " dmem_rdata"}, dmem_rdata, 32'h0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        if (v.is_d) begin
            dmem_read    = !v.wr;
            dmem_write   = v.wr;
            dmem_address = v.addr;
            dmem_wmask   = v.wmask;
            dmem_wdata   = v.wdata;
        end else begin
            imem_read    = 1'b1;
            imem_address = v.addr;
        end
        tick();
        for (int j = 1; j <= v.lat; j++) begin
            mem_resp  = (j == v.lat);
            mem_rdata = (j == v.lat) ? v.mrdata : 32'hBAD0_BAD0;
            chk({nm, " mem_read"},  {31'b0, mem_read},  v.is_d ? {31'b0, !v.wr} : 32'h1);
            chk({nm, " mem_write"}, {31'b0, mem_write}, {31'b0, v.is_d & v.wr});
            chk({nm, " mem_address"}, mem_address, v.addr);
            chk({nm, " mem_wmask"}, {28'b0, mem_wmask}, v.is_d ? {28'b0, v.wmask} : 32'h0);
            chk({nm, " mem_wdata"}, mem_wdata, v.is_d ? v.wdata : 32'h0);
            chk({nm, " early resp"}, {30'b0, imem_resp, dmem_resp}, 32'h0);
            tick();
        end
        mem_resp  = 1'b0;
        mem_rdata = '0;
        chk({nm, " mem idle in resp"}, {30'b0, mem_read, mem_write}, 32'h0);
        chk({nm, " imem_resp"}, {31'b0, imem_resp}, {31'b0, !v.is_d});
        chk({nm, " dmem_resp"}, {31'b0, dmem_resp}, {31'b0, v.is_d});
        chk({nm, " imem_rdata"}, imem_rdata, v.is_d ? 32'h0 : v.exp_rdata);
        chk({nm, " dmem_rdata"}, dmem_rdata, v.is_d ? v.exp_rdata : 32'h0);
        chk({nm, " err_timeout"}, {31'b0, err_timeout}, 32'h0);
        drop_reqs();
        tick();
        chk_quiet({nm, " after"});
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 4'h0, 32'h0,          32'h0000_0013, 2, 32'h0000_0013};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_1000, 4'h0, 32'h0,          32'h1234_5678, 1, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_3004, 4'h3, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_2ABC, 4'h0, 32'h0,          32'hCAFE_F00D, 3, 32'hCAFE_F00D};
        vecs[4] = '{1'b0, 1'b0, 32'h8000_0000, 4'h0, 32'h0,          32'hFFFF_FFFF, 1, 32'hFFFF_FFFF};

        rst       = 1'b1;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        drop_reqs();
        tick();
        tick();
        chk_quiet("reset");
        chk("reset mem_address", mem_address, 32'h0);
        chk("reset err", {31'b0, err_timeout}, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
        end

        // mem_resp while idle must not produce a completion
        mem_resp  = 1'b1;
        mem_rdata = 32'h0000_0777;
        tick();
        mem_resp  = 1'b0;
        chk_quiet("stray resp c1");
        tick();
        chk_quiet("stray resp c2");

        // simultaneous fetch and data: data goes first
        imem_read    = 1'b1;
        imem_address = 32'h0000_0100;
        dmem_read    = 1'b1;
        dmem_address = 32'h0000_2000;
        tick();
        chk("sim first addr", mem_address, 32'h0000_2000);
        chk("sim first read", {31'b0, mem_read}, 32'h1);
        mem_resp  = 1'b1;
        mem_rdata = 32'hAAAA_0001;
        tick();
        mem_resp  = 1'b0;
        chk("sim dmem_resp", {31'b0, dmem_resp}, 32'h1);
        chk("sim imem_resp excl", {31'b0, imem_resp}, 32'h0);
        chk("sim dmem_rdata", dmem_rdata, 32'hAAAA_0001);
        dmem_read = 1'b0;
        tick();
        chk_quiet("sim idle gap");
        tick();
        chk("sim second addr", mem_address, 32'h0000_0100);
        chk("sim second read", {31'b0, mem_read}, 32'h1);
        mem_resp  = 1'b1;
        mem_rdata = 32'hBBBB_0002;
        tick();
        mem_resp  = 1'b0;
        chk("sim imem_resp", {31'b0, imem_resp}, 32'h1);
        chk("sim dmem_resp excl", {31'b0, dmem_resp}, 32'h0);
        chk("sim imem_rdata", imem_rdata, 32'hBBBB_0002);
        drop_reqs();
        tick();
        chk_quiet("sim after");

        // live fetch address changes must not reach the memory
        imem_read    = 1'b1;
        imem_address = 32'h0000_0200;
        tick();
        imem_address = 32'hFFFF_0000;
        chk("hold addr c1", mem_address, 32'h0000_0200);
        tick();
        chk("hold addr c2", mem_address, 32'h0000_0200);
        mem_resp  = 1'b1;
        mem_rdata = 32'h0000_0055;
        tick();
        mem_resp  = 1'b0;
        chk("hold imem_resp", {31'b0, imem_resp}, 32'h1);
        chk("hold imem_rdata", imem_rdata, 32'h0000_0055);
        drop_reqs();
        tick();

        // withhold mem_resp: flag after exactly 8 waiting cycles, transaction keeps waiting
        imem_read    = 1'b1;
        imem_address = 32'h0000_0040;
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        chk("timeout before", {31'b0, err_timeout}, 32'h0);
        tick();
        chk("timeout set", {31'b0, err_timeout}, 32'h1);
        chk("timeout still reading", {31'b0, mem_read}, 32'h1);
        mem_resp  = 1'b1;
        mem_rdata = 32'h0000_0013;
        tick();
        mem_resp  = 1'b0;
        chk("timeout imem_resp", {31'b0, imem_resp}, 32'h1);
        chk("timeout imem_rdata", imem_rdata, 32'h0000_0013);
        chk("timeout sticky resp", {31'b0, err_timeout}, 32'h1);
        drop_reqs();
        tick();
        chk("timeout sticky idle", {31'b0, err_timeout}, 32'h1);

        // reset mid data transaction: abandoned, then re-issued from IDLE
        dmem_read    = 1'b1;
        dmem_address = 32'h0000_0500;
        tick();
        chk("rst pre read", {31'b0, mem_read}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk_quiet("rst async");
        chk("rst async addr", mem_address, 32'h0);
        chk("rst async err", {31'b0, err_timeout}, 32'h0);
        tick();
        chk_quiet("rst held");
        tick();
        rst = 1'b0;
        tick();
        chk("rst reissue read", {31'b0, mem_read}, 32'h1);
        chk("rst reissue addr", mem_address, 32'h0000_0500);
        chk("rst reissue no resp", {30'b0, imem_resp, dmem_resp}, 32'h0);
        mem_resp  = 1'b1;
        mem_rdata = 32'h0000_0099;
        tick();
        mem_resp  = 1'b0;
        chk("rst dmem_resp", {31'b0, dmem_resp}, 32'h1);
        chk("rst dmem_rdata", dmem_rdata, 32'h0000_0099);
        drop_reqs();
        tick();
        chk_quiet("rst after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
